sigma_delta_fast_ctrl: RTL

Sequencer and serializer for the lookup-table fast sigma-delta modulator. It accepts signed samples over a valid/ready handshake and issues one modulator update per sample. It captures each OUTLEN-bit parallel word and shifts it out LSB-first as a 1-bit stream at a programmable bit rate. Gaps in the sample supply are filled with an alternating zero-mean idle pattern, and each gap is flagged as an underrun.

---
 rtl/sigma_delta_fast_ctrl_if.sv | 28 ++
 rtl/sigma_delta_fast_ctrl.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/sigma_delta_fast_ctrl_if.sv
// Sample handshake and modulator bus for sigma_delta_fast_ctrl.
//   master : controller side (takes samples, drives the modulator)
//   slave  : environment side (offers samples, models the modulator)
// Signals:
//   sampleIn/sampleValid/sampleReady : valid/ready sample stream
//   sdRst/sdEn/sdIn                  : modulator reset, update strobe, input
//   sdWord                           : modulator parallel word, LSB sent first
interface sigma_delta_fast_ctrl_if #(
  parameter int WIDTH  = 4,
  parameter int OUTLEN = 1 << WIDTH
);
  logic signed [WIDTH-1:0] sampleIn;
  logic                    sampleValid;
  logic                    sampleReady;
  logic                    sdRst;
  logic                    sdEn;
  logic signed [WIDTH-1:0] sdIn;
  logic [OUTLEN-1:0]       sdWord;

  modport master (
    input  sampleIn, sampleValid, sdWord,
    output sampleReady, sdRst, sdEn, sdIn
  );
  modport slave (
    output sampleIn, sampleValid, sdWord,
    input  sampleReady, sdRst, sdEn, sdIn
  );
endinterface

// File: rtl/sigma_delta_fast_ctrl.sv
// Sequencer/serializer for the lookup-table sigma-delta modulator.
// Buffers one sample, fires one modulator update per sample, and shifts the
// resulting OUTLEN-bit word out LSB-first at a programmable bit period.
// When no word is ready at a word boundary, a zero-mean alternating idle
// pattern is sent instead and underrun pulses.
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   en         : run request (dropping it finishes the current word)
//   bitDiv     : bit period minus one, in clk cycles
//   bus        : sample handshake + modulator bus (master side)
//   bitOut     : serial stream, bitStrobe marks each new bit
//   underrun   : one-cycle pulse when the idle pattern is reloaded in RUN
//   busy       : controller not idle
module sigma_delta_fast_ctrl #(
  parameter int WIDTH     = 4,
  parameter int OUTLEN    = 1 << WIDTH,
  parameter int DIV_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic [DIV_WIDTH-1:0] bitDiv,
  sigma_delta_fast_ctrl_if.master bus,
  output logic                 bitOut,
  output logic                 bitStrobe,
  output logic                 underrun,
  output logic                 busy
);
  localparam int CW = (OUTLEN > 1) ? $clog2(OUTLEN) : 1;
  // Alternating 0/1 starting with 0 at bit0: zero mean on the output.
  localparam logic [OUTLEN-1:0] IDLE_PAT = {(OUTLEN/2){2'b10}};
  localparam logic [CW-1:0]     LAST_BIT = CW'(OUTLEN - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

  state_t                  r_state, w_next;
  logic                    r_bufValid;
  logic signed [WIDTH-1:0] r_sampleBuf;
  logic                    r_wordReady;
  logic                    r_sdEn;
  logic                    r_sdRst;
  logic signed [WIDTH-1:0] r_sdIn;
  logic [OUTLEN-1:0]       r_shiftReg;
  logic [CW-1:0]           r_bitCnt;
  logic [DIV_WIDTH-1:0]    r_divCnt;
  logic                    r_bitStrobe;
  logic                    r_underrun;

  logic w_active, w_run, w_bitEvt, w_wordEnd, w_fetch, w_accept;

  always_comb begin
    w_active  = (r_state != S_IDLE);
    w_run     = (r_state == S_RUN);
    // Live compare so a lowered bitDiv ends the current bit at once.
    w_bitEvt  = w_active && (r_divCnt >= bitDiv);
    w_wordEnd = w_bitEvt && (r_bitCnt == '0);
    // !r_sdEn keeps the update strobe from firing on back-to-back cycles.
    w_fetch   = w_run && r_bufValid && !r_wordReady && !r_sdEn;
    w_accept  = bus.sampleValid && bus.sampleReady;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (en) w_next = S_RUN;
      S_RUN:   if (!en) w_next = S_DRAIN;
      S_DRAIN: if (en) w_next = S_RUN;
               else if (w_wordEnd) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_bufValid  <= 1'b0;
      r_sampleBuf <= '0;
      r_wordReady <= 1'b0;
      r_sdEn      <= 1'b0;
      r_sdRst     <= 1'b1;
      r_sdIn      <= '0;
      r_shiftReg  <= IDLE_PAT;
      r_bitCnt    <= LAST_BIT;
      r_divCnt    <= '0;
      r_bitStrobe <= 1'b0;
      r_underrun  <= 1'b0;
    end else begin
      r_state     <= w_next;
      r_sdRst     <= (w_next == S_IDLE);
      r_sdEn      <= w_fetch;
      r_bitStrobe <= w_bitEvt;
      r_underrun  <= 1'b0;

      // Accept and fetch are mutually exclusive: accept needs an empty buffer.
      if (w_fetch) begin
        r_sdIn     <= r_sampleBuf;
        r_bufValid <= 1'b0;
      end else if (w_accept) begin
        r_sampleBuf <= bus.sampleIn;
        r_bufValid  <= 1'b1;
      end

      if (r_state == S_IDLE) begin
        if (en) begin
          r_shiftReg <= IDLE_PAT;
          r_bitCnt   <= LAST_BIT;
          r_divCnt   <= '0;
        end
      end else begin
        r_divCnt <= w_bitEvt ? '0 : r_divCnt + 1'b1;
        if (w_bitEvt) begin
          if (r_bitCnt != '0) begin
            r_shiftReg <= r_shiftReg >> 1;
            r_bitCnt   <= r_bitCnt - 1'b1;
          end else begin
            r_bitCnt <= LAST_BIT;
            if (w_run) begin
              if (r_wordReady) begin
                r_shiftReg  <= bus.sdWord;
                r_wordReady <= 1'b0;
              end else begin
                r_shiftReg <= IDLE_PAT;
                r_underrun <= 1'b1;
              end
            end else if (!en) begin
              // Drain finished: a word fetched meanwhile is dropped.
              r_wordReady <= 1'b0;
            end
          end
        end
      end

      // sdWord is valid from the cycle after the update strobe. A reload in
      // the same cycle saw wordReady=0, so setting here never loses a word.
      if (r_sdEn) r_wordReady <= 1'b1;
    end
  end

  assign bus.sampleReady = !r_bufValid && !rst;
  assign bus.sdRst       = r_sdRst;
  assign bus.sdEn        = r_sdEn;
  assign bus.sdIn        = r_sdIn;
  assign bitOut          = w_active && r_shiftReg[0];
  assign bitStrobe       = r_bitStrobe;
  assign underrun        = r_underrun;
  assign busy            = w_active;
endmodule
